pixel_fetch: RTL
================

PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter FRAME_PIXELS, default 307200, pixels per frame (640x480).
REQ-002 Parameter FIFO_DEPTH, default 4, prefetch entries (power of two, 2..16).
REQ-003 Parameter ADDR_W, default 19, memory word address width.
REQ-004 clock  in  1  system clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 frame_start  in  1  one-cycle pulse: restart fetch at address 0.
REQ-007 read_en  in  1  consumer pop request, one pixel per asserted cycle.
REQ-008 data  out  24  registered pixel {R[23:16],G[15:8],B[7:0]}.
REQ-009 mem_addr  out  ADDR_W  word address of current read request.
REQ-010 mem_req  out  1  read request, held until mem_ack.
REQ-011 mem_ack  in  1  one-cycle acknowledge; mem_rdata valid same cycle.
REQ-012 mem_rdata  in  24  read data.
REQ-013 underflow  out  1  sticky pop-while-empty flag (see Configuration).

Function
REQ-014 Fetch FSM SHALL have states IDLE, REQ, DRAIN.
REQ-015 IDLE->REQ when fifo_count + outstanding < FIFO_DEPTH and no frame_start; mem_req=1 only in REQ and DRAIN.
REQ-016 REQ: on mem_ack write mem_rdata into FIFO, increment mem_addr, return to IDLE (re-request next cycle allowed).
REQ-017 mem_addr SHALL count 0..FRAME_PIXELS-1, then wrap to 0; mem_addr and mem_req stable while waiting for ack.
REQ-018 frame_start in IDLE: flush FIFO, mem_addr=0 next cycle, stay IDLE.
REQ-019 frame_start in REQ without same-cycle mem_ack: go DRAIN; flush FIFO, mem_addr=0.
REQ-020 DRAIN: hold mem_req until mem_ack, discard that data, go IDLE; mem_addr already 0.
REQ-021 frame_start in REQ with same-cycle mem_ack: data discarded, flush, mem_addr=0, go IDLE.
REQ-022 read_en with FIFO non-empty: pop head, data updates on next clock edge (latency 1).
REQ-023 read_en with FIFO empty: data holds; pop ignored; underflow event.
REQ-024 Same-cycle FIFO write and pop: both occur, count unchanged; FIFO write when empty and pop same cycle counts as empty (no bypass).
REQ-025 frame_start with read_en same cycle: frame_start wins, no pop, data holds.
REQ-026 FIFO SHALL never overflow; outstanding request reserves one slot.

Reset
REQ-027 reset SHALL force: state IDLE, FIFO empty, mem_addr=0, mem_req=0, data=24'h000000, underflow=0.
REQ-028 reset mid-request: mem_req drops next edge; a late mem_ack after reset SHALL be ignored.
REQ-029 First mem_req SHALL assert no earlier than the 2nd cycle after reset deasserts.

Configuration
REQ-030 Macro PIXEL_FETCH_UNDERFLOW_EN defined: underflow sets on any REQ-023 event, clears only on reset or frame_start.
REQ-031 Macro undefined: underflow tied 0, no detection logic; all other behaviour identical.

Verification
REQ-032 Reset, zero-wait memory (ack one cycle after req): mem_addr 0,1,2,3 requested; requests stop at 4 buffered; mem_req=0.
REQ-033 FIFO full with 0x000001..0x000004, read_en 4 cycles -> data 0x000001..0x000004 on successive edges, refetch begins.
REQ-034 Run addresses to 307199 -> next mem_addr=0 without frame_start.
REQ-035 frame_start while mem_req pending, ack 3 cycles later -> that data discarded, next request at mem_addr 0, FIFO empty.
REQ-036 Memory stalled, read_en on empty FIFO -> data unchanged; underflow=1 with macro, 0 without; frame_start clears it.
REQ-037 reset asserted mid-request, stray mem_ack next cycle -> FIFO stays empty, mem_addr=0.

Source files
------------

// File: rtl/pixel_fetch.sv
// pixel_fetch: prefetches frame pixels from word memory into a small FIFO.
// Define PIXEL_FETCH_UNDERFLOW_EN to build the sticky underflow flag.
module pixel_fetch #(
   parameter int FRAME_PIXELS = 307200,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_W       = 19
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              read_en,
   output logic [23:0]       data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [23:0]       mem_rdata,
   output logic              underflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t           state;
   state_t           state_next;
   logic [23:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   // frame_start outranks both a returning word and a consumer pop
   assign fifo_empty = (count == '0);
   assign push       = (state == REQ) && mem_ack && !frame_start;
   assign pop        = read_en && !fifo_empty && !frame_start;

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // only IDLE issues, so count < depth here also covers the reserved slot
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!frame_start && (count < DEPTH_C))
               state_next = REQ;
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_next = IDLE;
            else if (frame_start)
               state_next = DRAIN;
         end
         DRAIN: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || frame_start)
         mem_addr <= '0;
      else if (push)
         mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset || frame_start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         fifo_mem[wr_ptr] <= mem_rdata;
   end

   always_ff @(posedge clock) begin
      if (reset)
         data <= '0;
      else if (pop)
         data <= fifo_mem[rd_ptr];
   end

`ifdef PIXEL_FETCH_UNDERFLOW_EN
   always_ff @(posedge clock) begin
      if (reset || frame_start)
         underflow <= 1'b0;
      else if (read_en && fifo_empty)
         underflow <= 1'b1;
   end
`else
   assign underflow = 1'b0;
`endif

endmodule
